// File: rtl/takvim_pkg.sv
// takvim_pkg: calendar constants, FSM state type and small mod-7 helper
package takvim_pkg;
    localparam logic [8:0] GUN_NORMAL_YIL  = 9'd358;
    localparam logic [8:0] GUN_ARTIK_YIL   = 9'd359;
    localparam logic [4:0] GUN_AY          = 5'd30;
    localparam logic [4:0] GUN_SUBAT       = 5'd28;
    localparam logic [4:0] GUN_SUBAT_ARTIK = 5'd29;
    localparam logic [3:0] AY_SAYISI       = 4'd12;
    localparam logic [4:0] SAAT_GUN        = 5'd24;
    localparam logic [3:0] SUBAT_INDEKS    = 4'd1;
    localparam logic [3:0] HAFTA           = 4'd7;
    // 358 % 7 = 1, 359 % 7 = 2
    localparam logic [3:0] KAYMA_NORMAL_YIL = 4'd1;
    localparam logic [3:0] KAYMA_ARTIK_YIL  = 4'd2;

    typedef enum logic [1:0] {BOSTA, YIL, AY, SON} durum_t;

    // single compare-and-subtract; valid for x < 14
    function automatic logic [2:0] mod7(input logic [3:0] x);
        return x >= HAFTA ? 3'(x - HAFTA) : x[2:0];
    endfunction
endpackage

// File: rtl/takvim_ay_uzunlugu.sv
// takvim_ay_uzunlugu: month length and length mod 7 for a month index and leap flag
// ports: ay (0-based month), artik (leap year) -> uzunluk (days), kayma (days mod 7)
module takvim_ay_uzunlugu
    import takvim_pkg::*;
(
    input  logic [3:0] ay,
    input  logic       artik,
    output logic [4:0] uzunluk,
    output logic [2:0] kayma
);
    always_comb begin
        uzunluk = ay == SUBAT_INDEKS ? (artik ? GUN_SUBAT_ARTIK : GUN_SUBAT) : GUN_AY;
        // lengths are 28..30 and 28 = 4*7, so the remainder is just the excess over 28
        kayma = 3'(uzunluk - GUN_SUBAT);
    end
endmodule

// File: rtl/takvim_kodlayici.sv
// takvim_kodlayici: iterative date -> absolute day/hour index and weekday encoder
// ports: clk, rst (async high); basla + yil/ay/ay_gunu/saat request;
//        mesgul busy, gecerli one-cycle result strobe, hata invalid request,
//        toplam_gun, toplam_saat, haftanin_gunu, artik_yil results
module takvim_kodlayici
    import takvim_pkg::*;
#(
    parameter int MAX_YIL = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        basla,
    input  logic [4:0]  yil,
    input  logic [3:0]  ay,
    input  logic [4:0]  ay_gunu,
    input  logic [4:0]  saat,
    output logic        mesgul,
    output logic        gecerli,
    output logic        hata,
    output logic [12:0] toplam_gun,
    output logic [17:0] toplam_saat,
    output logic [2:0]  haftanin_gunu,
    output logic        artik_yil
);
    localparam logic [4:0] MAX_Y = 5'(MAX_YIL);

    durum_t durum, sonraki;
    logic [4:0]  yil_r, gun_r, saat_r, i;
    logic [3:0]  ay_r;
    logic        artik_r, hata_r;
    logic [12:0] acc;
    logic [2:0]  hg;
    logic [4:0]  ay_uzun;
    logic [2:0]  ay_kayma, gun_kayma, hg_son;
    logic [12:0] gun_top;
    logic [17:0] gun18, saat_top;
    logic        bosta, artik_giris, gecersiz, son_yil, son_ay, yil_artik;

    assign bosta       = durum == BOSTA;
    assign artik_giris = yil[1:0] == 2'd0;
    assign son_yil     = i == yil_r - 5'd1;
    assign son_ay      = i == {1'b0, 4'(ay_r - 4'd1)};
    assign yil_artik   = i[1:0] == 2'd0;

    // validation looks at the live inputs, the AY loop at the latched month counter
    takvim_ay_uzunlugu u_ay (
        .ay      (bosta ? ay : i[3:0]),
        .artik   (bosta ? artik_giris : artik_r),
        .uzunluk (ay_uzun),
        .kayma   (ay_kayma)
    );

    assign gecersiz = yil > MAX_Y || ay >= AY_SAYISI || saat >= SAAT_GUN || ay_gunu >= ay_uzun;

    // 8 = 1 (mod 7), so x mod 7 = (x[4:3] + x[2:0]) mod 7 with the sum below 14
    assign gun_kayma = mod7(4'(gun_r[4:3]) + 4'(gun_r[2:0]));
    assign hg_son    = mod7({1'b0, hg} + {1'b0, gun_kayma});
    assign gun_top   = acc + 13'(gun_r);
    assign gun18     = 18'(gun_top);
    assign saat_top  = (gun18 << 4) + (gun18 << 3) + 18'(saat_r);

    always_ff @(posedge clk or posedge rst)
        if (rst) durum <= BOSTA;
        else durum <= sonraki;

    always_comb begin
        sonraki = durum;
        case (durum)
            BOSTA:   if (basla) sonraki = gecersiz ? SON : yil != 5'd0 ? YIL : ay != 4'd0 ? AY : SON;
            YIL:     if (son_yil) sonraki = ay_r != 4'd0 ? AY : SON;
            AY:      if (son_ay) sonraki = SON;
            default: sonraki = BOSTA;
        endcase
    end

    always_comb mesgul = !bosta;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            yil_r         <= '0;
            ay_r          <= '0;
            gun_r         <= '0;
            saat_r        <= '0;
            artik_r       <= 1'b0;
            hata_r        <= 1'b0;
            acc           <= '0;
            hg            <= '0;
            i             <= '0;
            gecerli       <= 1'b0;
            hata          <= 1'b0;
            toplam_gun    <= '0;
            toplam_saat   <= '0;
            haftanin_gunu <= '0;
            artik_yil     <= 1'b0;
        end else begin
            gecerli <= 1'b0;
            case (durum)
                BOSTA: if (basla) begin
                    yil_r   <= yil;
                    ay_r    <= ay;
                    gun_r   <= ay_gunu;
                    saat_r  <= saat;
                    artik_r <= artik_giris;
                    hata_r  <= gecersiz;
                    acc     <= '0;
                    hg      <= '0;
                    i       <= '0;
                end
                YIL: begin
                    acc <= acc + 13'(yil_artik ? GUN_ARTIK_YIL : GUN_NORMAL_YIL);
                    hg  <= mod7({1'b0, hg} + (yil_artik ? KAYMA_ARTIK_YIL : KAYMA_NORMAL_YIL));
                    i   <= son_yil ? 5'd0 : i + 5'd1;
                end
                AY: begin
                    acc <= acc + 13'(ay_uzun);
                    hg  <= mod7({1'b0, hg} + {1'b0, ay_kayma});
                    i   <= i + 5'd1;
                end
                default: begin
                    gecerli       <= 1'b1;
                    hata          <= hata_r;
                    artik_yil     <= artik_r;
                    toplam_gun    <= hata_r ? '0 : gun_top;
                    toplam_saat   <= hata_r ? '0 : saat_top;
                    haftanin_gunu <= hata_r ? '0 : hg_son;
                end
            endcase
        end
endmodule

// File: doc/takvim_kodlayici.md
Name: takvim_kodlayici

Overview:
Sequential calendar encoder. It converts a calendar date (year, month, day-of-month, hour) into an absolute day index, an absolute hour index and a weekday. Calendar rules: year y has 359 days if y%4==0 (year 0 is leap), otherwise 358; there are 12 months of 30 days, except month 1 (February), which has 29 days in a leap year and 28 otherwise. The block sits beside the date decoder and produces the counter form that feeds it, using an iterative start/busy/valid handshake.

Parameters:
MAX_YIL, 20, highest accepted year value (inclusive); fixes yil width at 5 bits.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
basla  input  1  start request; sampled only in BOSTA.
yil  input  5  year, 0..MAX_YIL.
ay  input  4  month, 0-based, 0..11.
ay_gunu  input  5  day of month, 0-based.
saat  input  5  hour, 0..23.
mesgul  output  1  high in every state except BOSTA.
gecerli  output  1  one-cycle pulse when results update.
hata  output  1  registered; 1 = last request was invalid.
toplam_gun  output  13  absolute day index; day 0 = year 0, month 0, day 0.
toplam_saat  output  18  toplam_gun*24 + saat.
haftanin_gunu  output  3  toplam_gun % 7.
artik_yil  output  1  registered; 1 when yil%4==0 for the last request.

Behaviour:
- Reset (asynchronous, any state): state = BOSTA; all outputs 0; internal accumulators cleared. No gecerli is produced for a request that was aborted by reset.
- States: BOSTA, YIL, AY, SON.
- BOSTA:
  - On an edge with basla=1, latch all inputs and clear the day accumulator (acc), the weekday accumulator (hg) and the loop counter (i).
  - Validation: the request is invalid if yil>MAX_YIL, ay>11, saat>23, or ay_gunu >= length of month ay in year yil.
  - Next state: invalid → SON with an error flag; else yil>0 → YIL; else ay>0 → AY; else SON.
- YIL: one edge per year i = 0..yil-1.
  - acc += 358 or 359.
  - hg = (hg + 1 or 2) mod 7, since 358%7=1 and 359%7=2.
  - After the last year: clear i, then go to AY if ay>0, else SON.
- AY: one edge per month i = 0..ay-1, using the latched year's leap status.
  - acc += 30/29/28.
  - hg += 2/1/0 mod 7.
  - After the last month → SON.
- SON: one edge, then back to BOSTA.
  - Registers toplam_gun = acc + ay_gunu, haftanin_gunu = (hg + ay_gunu) mod 7, toplam_saat = toplam_gun*24 + saat, artik_yil, hata=0; gecerli=1 for the following cycle.
  - Error path: toplam_gun, toplam_saat and haftanin_gunu are forced to 0, hata=1, gecerli still pulses.
- Latency: counting the basla-sampling edge as edge 1, outputs update at edge yil+ay+2 for valid requests and at edge 2 for invalid ones.
- mesgul falls in the same cycle gecerli rises.
- basla while mesgul=1 is ignored; it is not queued.
- A new request may be accepted on the edge where gecerli is high.
- Outputs hold their last values between completions.
- Width rules:
  - The maximum toplam_gun is 7523, so 13 bits is sufficient.
  - The maximum toplam_saat is 180575, so 18 bits is sufficient.
  - Multiply by 24 as (x<<4)+(x<<3). No other multipliers or dividers.
  - Modulo 7 only on values below 14, as a compare-and-subtract.

Decomposition:
- Shared package takvim_pkg:
  - Constants: GUN_NORMAL_YIL=358, GUN_ARTIK_YIL=359, GUN_AY=30, GUN_SUBAT=28, GUN_SUBAT_ARTIK=29, AY_SAYISI=12, SAAT_GUN=24, SUBAT_INDEKS=1, HAFTA=7.
  - State enum.
- One natural sub-module: takvim_ay_uzunlugu (combinational). Given month index and leap flag, it returns the month length and length%7. It is shared by validation and the AY state.

Test Plan:
1. Zero date: yil=0, ay=0, ay_gunu=0, saat=0, basla pulse → edge 2: toplam_gun=0, toplam_saat=0, haftanin_gunu=0, artik_yil=1, hata=0; gecerli one cycle.
2. Non-leap March: yil=1, ay=2, ay_gunu=4, saat=5 → toplam_gun=421, haftanin_gunu=1, toplam_saat=10109, artik_yil=0; gecerli after edge 5.
3. Leap February boundary:
   - yil=0, ay=1, ay_gunu=28 → valid: toplam_gun=58, haftanin_gunu=2.
   - yil=1, ay=1, ay_gunu=28 → hata=1, outputs 0, gecerli after edge 2.
4. Maximum: yil=20, ay=11, ay_gunu=29, saat=23 → toplam_gun=7523, haftanin_gunu=5, toplam_saat=180575; mesgul high for 32 cycles, gecerli after edge 33.
5. Handshake and invalid inputs:
   - basla held high through a yil=4, ay=2, ay_gunu=0 request → exactly one result: toplam_gun=1492, haftanin_gunu=1, toplam_saat=35808. A back-to-back request is accepted on the gecerli cycle.
   - saat=24 → hata=1.
   - ay=12 → hata=1.
6. Reset mid-operation: assert rst asynchronously (between edges) during YIL of the scenario-4 request → mesgul, gecerli and all outputs go to 0 immediately. No gecerli follows. The next request (scenario 2) completes correctly.
